// File: rtl/keccak_pkg.sv
// Shared Keccak squeeze definitions: the sponge-reader FSM states, default widths
// and the (x,y) -> lane index mapping.
package keccak_pkg;

    localparam int L_DEFAULT           = 6;
    localparam int RATE_LANES_SHA3_256 = 17;
    // Wide enough for any rate of up to 24 lanes.
    localparam int LANE_IDX_W          = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STATE = 2'd1,
        EMIT       = 2'd2,
        PERMUTE    = 2'd3
    } sq_state_e;

    function automatic int lane_index(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Picks lane[lane_idx_i] out of the captured rate portion of the state.
// Optional byte reversal for big-endian consumers: KECCAK_SQUEEZE_BYTESWAP_EN.
module keccak_lane_select
    import keccak_pkg::*;
#(
    parameter int W          = 64,
    parameter int RATE_LANES = RATE_LANES_SHA3_256
)(
    input  logic [RATE_LANES*W-1:0] rate_i,
    input  logic [LANE_IDX_W-1:0]   lane_idx_i,
    output logic [W-1:0]            lane_o
);

    logic [W-1:0] lane_raw;

    // Only rate lanes appear in the mux, so capacity lanes can never be selected.
    always_comb begin
        lane_raw = '0;
        for (int k = 0; k < RATE_LANES; k++) begin
            if (lane_idx_i == LANE_IDX_W'(k)) begin
                lane_raw = rate_i[W*k +: W];
            end
        end
    end

`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    always_comb begin
        lane_o = '0;
        for (int i = 0; i < W / 8; i++) begin
            lane_o[8*i +: 8] = lane_raw[W-8-8*i +: 8];
        end
    end
`else
    assign lane_o = lane_raw;
`endif

endmodule

// File: rtl/keccak_squeeze.sv
// Keccak sponge squeeze: captures a permuted state and streams its rate lanes,
// requesting further permutations until req_len lanes have been delivered.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int L          = L_DEFAULT,
    parameter int RATE_LANES = RATE_LANES_SHA3_256,
    parameter int LEN_W      = 16,
    localparam int W         = 1 << L,
    localparam int B         = 25 * W,
    localparam int RATE_W    = RATE_LANES * W
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic [B-1:0]     state_i,
    input  logic             state_valid_i,
    output logic             state_ready_o,
    output logic             permute_req_o,
    output logic [W-1:0]     out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             busy_o
);

    sq_state_e             state_q, state_d;
    logic [RATE_W-1:0]     rate_q;
    logic [LANE_IDX_W-1:0] lane_idx_q, lane_idx_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  capture;

    // The capacity portion of the state is never output.
    logic unused_capacity;
    assign unused_capacity = ^state_i[B-1:RATE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rate_q      <= '0;
            lane_idx_q  <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            remaining_q <= remaining_d;
            if (capture) begin
                rate_q <= state_i[RATE_W-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        remaining_d = remaining_q;
        capture     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && (req_len_i != '0)) begin
                    remaining_d = req_len_i;
                    state_d     = WAIT_STATE;
                end
            end
            WAIT_STATE: begin
                if (state_valid_i) begin
                    capture    = 1'b1;
                    lane_idx_d = '0;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (out_ready_i) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    // lane_idx wraps to 0 instead of running past the last rate lane.
                    if (remaining_q == LEN_W'(1)) begin
                        lane_idx_d = '0;
                        state_d    = IDLE;
                    end else if (lane_idx_q == LANE_IDX_W'(RATE_LANES - 1)) begin
                        lane_idx_d = '0;
                        state_d    = PERMUTE;
                    end else begin
                        lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
                    end
                end
            end
            PERMUTE: begin
                state_d = WAIT_STATE;
            end
            default: state_d = IDLE;
        endcase
    end

    // All handshake outputs decode directly from the state register.
    assign state_ready_o = (state_q == WAIT_STATE);
    assign permute_req_o = (state_q == PERMUTE);
    assign out_valid_o   = (state_q == EMIT);
    assign out_last_o    = (state_q == EMIT) && (remaining_q == LEN_W'(1));
    assign busy_o        = (state_q != IDLE);

    keccak_lane_select #(
        .W          (W),
        .RATE_LANES (RATE_LANES)
    ) u_lane_select (
        .rate_i     (rate_q),
        .lane_idx_i (lane_idx_q),
        .lane_o     (out_data_o)
    );

endmodule
